bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
Two-master bus arbiter that generates the 2-bit one-hot bus_grant consumed by the master-side mux. Encoding: 2'b01 = master 1, 2'b10 = master 2, 2'b00 = no owner. Holds the grant for a whole transaction and uses round-robin fairness between masters. A timeout watchdog forces release if the slave never completes.

Parameters:
TIMEOUT_CYCLES, 256, max cycles a grant is held without slave_tx_done before forced release (must be >= 2)
TIMEOUT_EN, 1, 1 = watchdog active; 0 = grant held until done/abandon only
CNT_W, $clog2(TIMEOUT_CYCLES), width of the hold counter (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
m1_request  input  1  master 1 requests bus, held high for the transaction
m2_request  input  1  master 2 requests bus, held high for the transaction
slave_tx_done  input  1  one-cycle pulse from slave side: current transaction complete
bus_grant  output  2  one-hot grant to mux: 00 none, 01 m1, 10 m2 (registered)
m1_grant  output  1  equals bus_grant[0]
m2_grant  output  1  equals bus_grant[1]
bus_busy  output  1  high whenever bus_grant != 00
timeout_err  output  1  one-cycle pulse when the watchdog forces release

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, bus_grant=00, m1_grant=0, m2_grant=0, bus_busy=0, timeout_err=0, hold counter=0, last_owner=M2 (so m1 wins the first contention).
- States:
  - IDLE: bus_grant=00.
  - OWN_M1: bus_grant=01.
  - OWN_M2: bus_grant=10.
- bus_grant is a direct registered decode of the state. No combinational path from request to grant.
- IDLE transitions:
  - Only m1_request -> OWN_M1.
  - Only m2_request -> OWN_M2.
  - Both requests -> grant the master != last_owner.
  - Neither -> stay in IDLE.
  - Grant is visible the cycle after the request is sampled (latency 1).
- OWN_Mx, counter handling:
  - Counter clears on entry and increments every cycle in the state.
  - last_owner is updated to x on entry.
- OWN_Mx, release to IDLE on any of:
  - slave_tx_done=1.
  - mx_request=0 (abandon).
  - TIMEOUT_EN=1 and counter==TIMEOUT_CYCLES-1: pulse timeout_err the same cycle the release decision is registered, i.e. timeout_err is high in the first IDLE cycle.
- Turnaround: every release passes through at least one IDLE cycle (bus_grant=00). Direct OWN_M1 -> OWN_M2 is illegal, so two grant bits are never asserted together, even transiently.
- Simultaneous events:
  - slave_tx_done with timeout in the same cycle: normal release, no timeout_err.
  - Abandon with done in the same cycle: normal release.
  - Requests arriving while owned are ignored until IDLE.
- Counter saturates and never wraps. When TIMEOUT_EN=0 the counter is held at 0.
- slave_tx_done while in IDLE is ignored.
- Reset asserted mid-grant: outputs go to reset values immediately (asynchronously). After rstn release the first contention goes to m1 again.
- Assertions:
  - bus_grant never equals 11.
  - bus_busy == |bus_grant.
  - timeout_err only follows an OWN state.

Decomposition:
- Package bus_arb_pkg:
  - Grant encodings GRANT_NONE=2'b00, GRANT_M1=2'b01, GRANT_M2=2'b10.
  - State enum (IDLE, OWN_M1, OWN_M2).
  - Owner id type.
- Sub-module bus_arb_timer: hold counter with clear/enable/saturate, parameterised by TIMEOUT_CYCLES.
  - Outputs expired = (TIMEOUT_EN && count==TIMEOUT_CYCLES-1).
  - Instantiated once.

Test Plan:
- Reset: rstn=0 with requests toggling -> bus_grant=00, bus_busy=0, timeout_err=0 throughout; rstn release with m2_request only -> bus_grant=10 one cycle later.
- Single owner: m1_request high at cycle 0 -> bus_grant=01 at cycle 1; slave_tx_done pulse at cycle 5 -> bus_grant=00 at cycle 6.
- Round-robin: both requests held high, slave_tx_done every 4th cycle -> grant sequence 01,00,10,00,01,00,10 with exactly one 00 cycle between owners.
- Timeout: TIMEOUT_CYCLES=8, m2_request held, no done -> bus_grant=10 for exactly 8 cycles, then 00 with timeout_err=1 for one cycle; m2 is re-granted the next cycle if still requesting and m1 is idle.
- Done/timeout collision: slave_tx_done arrives on the expiry cycle -> release with timeout_err=0. Abandon test: m1 drops its request at cycle 3 -> bus_grant=00 at cycle 4.
- Reset mid-grant: rstn=0 while bus_grant=10 -> bus_grant=00 before the next clock edge; after release with both requesting -> bus_grant=01.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and grant encodings for the two-master bus arbiter.
package bus_arb_pkg;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M1   = 2'b01;
  localparam logic [1:0] GRANT_M2   = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OWN_M1 = 2'b01,
    OWN_M2 = 2'b10
  } state_t;

  typedef enum logic {
    OWNER_M1 = 1'b0,
    OWNER_M2 = 1'b1
  } owner_t;

  // One-hot grant word driven to the mux for a given arbiter state.
  function automatic logic [1:0] grant_of(input state_t s);
    logic [1:0] g;
    g = GRANT_NONE;
    case (s)
      OWN_M1:  g = GRANT_M1;
      OWN_M2:  g = GRANT_M2;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bus_arb_timer.sv
// Grant hold counter: cleared while idle, counts owned cycles, saturates at the
// expiry value and never wraps.
module bus_arb_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter bit          TIMEOUT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear || !TIMEOUT_EN) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = TIMEOUT_EN && (count == CNT_MAX);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with whole-transaction ownership, a
// mandatory idle turnaround between owners and a hold-time watchdog.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter bit          TIMEOUT_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       m1_request,
  input  logic       m2_request,
  input  logic       slave_tx_done,
  output logic [1:0] bus_grant,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       bus_busy,
  output logic       timeout_err
);

  state_t state, state_next;
  owner_t last_owner, owner_next;
  logic   tmo_next;
  logic   owned;
  logic   expired;

  assign owned = (state != IDLE);

  bus_arb_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_EN     (TIMEOUT_EN)
  ) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (!owned),
    .enable  (owned),
    .expired (expired)
  );

  // Next-state: done/abandon take priority over expiry so only a genuine
  // watchdog release raises timeout_err.
  always_comb begin
    state_next = state;
    owner_next = last_owner;
    tmo_next   = 1'b0;
    case (state)
      IDLE: begin
        if (m1_request && (!m2_request || (last_owner == OWNER_M2))) begin
          state_next = OWN_M1;
          owner_next = OWNER_M1;
        end else if (m2_request) begin
          state_next = OWN_M2;
          owner_next = OWNER_M2;
        end
      end
      OWN_M1: begin
        if (slave_tx_done || !m1_request) begin
          state_next = IDLE;
        end else if (expired) begin
          state_next = IDLE;
          tmo_next   = 1'b1;
        end
      end
      OWN_M2: begin
        if (slave_tx_done || !m2_request) begin
          state_next = IDLE;
        end else if (expired) begin
          state_next = IDLE;
          tmo_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so they track state exactly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      last_owner  <= OWNER_M2;
      bus_grant   <= GRANT_NONE;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      last_owner  <= owner_next;
      bus_grant   <= grant_of(state_next);
      bus_busy    <= (state_next != IDLE);
      timeout_err <= tmo_next;
    end
  end

  assign m1_grant = bus_grant[0];
  assign m2_grant = bus_grant[1];

  a_onehot: assert property (@(posedge clk) disable iff (!rstn) bus_grant != 2'b11);
  a_busy:   assert property (@(posedge clk) disable iff (!rstn) bus_busy == (|bus_grant));
  a_tmo:    assert property (@(posedge clk) disable iff (!rstn) timeout_err |-> ($past(state) != IDLE));

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a transaction-level owner model predicts
// grant/timeout per cycle, a monitor compares against the DUT.
module tb_bus_arbiter;

  localparam int unsigned T = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic       m1_request, m2_request, slave_tx_done;
  logic [1:0] bus_grant;
  logic       m1_grant, m2_grant, bus_busy, timeout_err;

  typedef struct packed {
    logic [1:0] grant;
    logic       tmo;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: who owns the bus, how many cycles the grant has been visible,
  // and who owned it last (1 or 2).
  int m_own, m_held, m_last;

  bus_arbiter #(
    .TIMEOUT_CYCLES (T),
    .TIMEOUT_EN     (1'b1)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .m1_request    (m1_request),
    .m2_request    (m2_request),
    .slave_tx_done (slave_tx_done),
    .bus_grant     (bus_grant),
    .m1_grant      (m1_grant),
    .m2_grant      (m2_grant),
    .bus_busy      (bus_busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_own  = 0;
    m_held = 0;
    m_last = 2;
  endfunction

  // Advance the model by one clock given the inputs sampled at that edge.
  function automatic exp_t model_step(input logic r, input logic a, input logic b, input logic d);
    exp_t e;
    logic req;
    e.tmo = 1'b0;
    if (!r) begin
      model_reset();
    end else if (m_own == 0) begin
      if (a && b)  m_own = (m_last == 1) ? 2 : 1;
      else if (a)  m_own = 1;
      else if (b)  m_own = 2;
      if (m_own != 0) begin
        m_last = m_own;
        m_held = 1;
      end
    end else begin
      req = (m_own == 1) ? a : b;
      if (d || !req) begin
        m_own = 0;
      end else if (m_held >= int'(T)) begin
        m_own = 0;
        e.tmo = 1'b1;
      end else begin
        m_held++;
      end
    end
    e.grant = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
    return e;
  endfunction

  // Apply one cycle of stimulus at a falling edge; returns at the next falling edge.
  task automatic drive(input logic r, input logic a, input logic b, input logic d);
    rstn          = r;
    m1_request    = a;
    m2_request    = b;
    slave_tx_done = d;
    if (!r) begin
      #1;
      chk("async_rst_grant", int'(bus_grant), 0);
      chk("async_rst_busy", int'(bus_busy), 0);
      chk("async_rst_tmo", int'(timeout_err), 0);
    end
    q.push_back(model_step(r, a, b, d));
    @(negedge clk);
  endtask

  // Monitor: outputs are presented every cycle; compare just after the rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("grant", int'(bus_grant), int'(e.grant));
      chk("timeout_err", int'(timeout_err), int'(e.tmo));
      chk("bus_busy", int'(bus_busy), int'(e.grant != 2'b00));
      chk("m1_grant", int'(m1_grant), int'(e.grant[0]));
      chk("m2_grant", int'(m2_grant), int'(e.grant[1]));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog bench did not finish got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic r1, r2, d, rr;
    model_reset();
    rstn = 1'b0; m1_request = 1'b0; m2_request = 1'b0; slave_tx_done = 1'b0;
    @(negedge clk);

    // Reset held with requests toggling, then release with m2 only.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("post_rst_m2_grant", int'(bus_grant), 2);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    chk("done_release", int'(bus_grant), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    // Single owner: grant at cycle 1, done at cycle 5 releases at cycle 6.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      chk("single_m1", int'(bus_grant), 1);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("single_release", int'(bus_grant), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    // Round-robin with both masters held and periodic done.
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 1'b1, 1'((i % 4) == 3));
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    // Timeout: m2 held with no done -> 8 granted cycles then a pulse.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      chk("tmo_hold", int'(bus_grant), 2);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("tmo_release", int'(bus_grant), 0);
    chk("tmo_pulse", int'(timeout_err), 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("tmo_regrant", int'(bus_grant), 2);
    chk("tmo_pulse_end", int'(timeout_err), 0);

    // Done colliding with expiry: normal release.
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    chk("collide_release", int'(bus_grant), 0);
    chk("collide_no_tmo", int'(timeout_err), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    // Abandon: m1 drops request at cycle 3.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("abandon_release", int'(bus_grant), 0);

    // Reset mid-grant, then both requesting -> m1 wins.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_first_contention", int'(bus_grant), 1);

    // Randomized traffic, with a low-done phase to exercise the watchdog.
    r1 = 1'b1; r2 = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!r1) r1 = ($urandom_range(0, 99) < 30);
      else if ($urandom_range(0, 99) < 4) r1 = 1'b0;
      if (!r2) r2 = ($urandom_range(0, 99) < 30);
      else if ($urandom_range(0, 99) < 4) r2 = 1'b0;
      d  = (i < 1500) ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 3);
      rr = ($urandom_range(0, 399) != 0);
      drive(rr, r1, r2, d);
    end

    chk("scoreboard_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
